// File: rtl/user_accel_ctrl.sv
// OBI-attached control block for a single user accelerator.
//
// Register window: addr_i[11:0] only. All decoding is on the full low 12 bits, so
// misaligned offsets are treated as unmapped.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   req_i/we_i/be_i/addr_i/wdata_i/aid_i OBI subordinate request
//   gnt_o/rvalid_o/rdata_o/rid_o/err_o   OBI subordinate response (gnt = req, 1-cycle rvalid)
//   accel_start_o                        one-cycle start pulse to the accelerator
//   accel_arg0_o/accel_arg1_o            argument registers, driven continuously
//   accel_done_i/accel_result_i          completion pulse and result from the accelerator
//   irq_o                                level interrupt on completion or timeout
module user_accel_ctrl #(
  parameter int unsigned IdWidth        = 1,
  parameter logic [31:0] DefaultTimeout = 32'h0000_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // OBI request
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  // OBI response
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               err_o,
  // Accelerator
  output logic               accel_start_o,
  output logic [31:0]        accel_arg0_o,
  output logic [31:0]        accel_arg1_o,
  input  logic               accel_done_i,
  input  logic [31:0]        accel_result_i,
  // Interrupt
  output logic               irq_o
);

  localparam logic [11:0] OffCtrl    = 12'h000;
  localparam logic [11:0] OffStatus  = 12'h004;
  localparam logic [11:0] OffArg0    = 12'h008;
  localparam logic [11:0] OffArg1    = 12'h00C;
  localparam logic [11:0] OffResult  = 12'h010;
  localparam logic [11:0] OffTimeout = 12'h014;
  localparam logic [11:0] OffCycles  = 12'h018;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e state_q, state_d;

  logic [31:0] arg0_q, arg0_d;
  logic [31:0] arg1_q, arg1_d;
  logic [31:0] result_q, result_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] cycles_q, cycles_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic        start_q, start_d;
  logic        irq_q;

  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [IdWidth-1:0] rid_q;
  logic               err_q;

  logic [11:0] off;
  logic        busy;
  logic [31:0] bmask;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ctrl_we, arg0_we, arg1_we, timeout_we;
  logic        start_cmd, clear_cmd;
  logic [31:0] cycles_inc;

  // Upper address bits select the window externally and are intentionally unused here.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:12];

  assign off   = addr_i[11:0];
  assign busy  = (state_q == StRun);
  assign bmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  // Register read mux and error decode.
  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (off)
      OffCtrl:    rsp_rdata = {30'd0, irq_en_q, 1'b0};
      OffStatus: begin
        rsp_rdata = {29'd0, tmo_q, done_q, busy};
        rsp_err   = we_i;
      end
      OffArg0: begin
        rsp_rdata = arg0_q;
        rsp_err   = we_i & busy;
      end
      OffArg1: begin
        rsp_rdata = arg1_q;
        rsp_err   = we_i & busy;
      end
      OffResult: begin
        rsp_rdata = result_q;
        rsp_err   = we_i;
      end
      OffTimeout: begin
        rsp_rdata = timeout_q;
        rsp_err   = we_i & busy;
      end
      OffCycles: begin
        rsp_rdata = cycles_q;
        rsp_err   = we_i;
      end
      default:    rsp_err = 1'b1;
    endcase
    if (we_i || rsp_err) begin
      rsp_rdata = '0;
    end
  end

  // Write strobes; each already excludes every error case.
  assign ctrl_we    = req_i & we_i & (off == OffCtrl) & be_i[0];
  assign arg0_we    = req_i & we_i & (off == OffArg0) & ~busy;
  assign arg1_we    = req_i & we_i & (off == OffArg1) & ~busy;
  assign timeout_we = req_i & we_i & (off == OffTimeout) & ~busy;
  assign start_cmd  = ctrl_we & wdata_i[0];
  assign clear_cmd  = ctrl_we & wdata_i[2];

  assign arg0_d    = arg0_we ? ((arg0_q & ~bmask) | (wdata_i & bmask)) : arg0_q;
  assign arg1_d    = arg1_we ? ((arg1_q & ~bmask) | (wdata_i & bmask)) : arg1_q;
  assign timeout_d = timeout_we ? ((timeout_q & ~bmask) | (wdata_i & bmask)) : timeout_q;
  assign irq_en_d  = ctrl_we ? wdata_i[1] : irq_en_q;

  assign cycles_inc = cycles_q + 32'd1;

  // Run-control FSM next state. CLEAR is applied first so that a flag set by a
  // finishing run in the same cycle is not lost.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    result_d = result_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    start_d  = 1'b0;

    if (clear_cmd) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_cmd) begin
          state_d  = StRun;
          cycles_d = '0;
          done_d   = 1'b0;
          tmo_d    = 1'b0;
          start_d  = 1'b1;
        end
      end
      StRun: begin
        if (cycles_q != 32'hFFFF_FFFF) begin
          cycles_d = cycles_inc;
        end
        // Completion takes priority over a coincident timeout expiry.
        if (accel_done_i) begin
          state_d  = StFinish;
          result_d = accel_result_i;
          done_d   = 1'b1;
          tmo_d    = 1'b0;
        end else if ((timeout_q != '0) && (cycles_inc == timeout_q)) begin
          state_d = StFinish;
          tmo_d   = 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      arg0_q    <= '0;
      arg1_q    <= '0;
      result_q  <= '0;
      timeout_q <= DefaultTimeout;
      cycles_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arg0_q    <= arg0_d;
      arg1_q    <= arg1_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      irq_q     <= irq_en_q & (done_q | tmo_q);
      rvalid_q  <= req_i;
      rdata_q   <= req_i ? rsp_rdata : '0;
      rid_q     <= req_i ? aid_i : '0;
      err_q     <= req_i & rsp_err;
    end
  end

  assign gnt_o         = req_i;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign rid_o         = rid_q;
  assign err_o         = err_q;
  assign accel_start_o = start_q;
  assign accel_arg0_o  = arg0_q;
  assign accel_arg1_o  = arg1_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_user_accel_ctrl.sv
module tb_user_accel_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [0:0]  aid_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [0:0]  rid_o;
  logic        err_o;
  logic        accel_start_o;
  logic [31:0] accel_arg0_o;
  logic [31:0] accel_arg1_o;
  logic        accel_done_i = 1'b0;
  logic [31:0] accel_result_i = '0;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int exp_starts = 0;

  user_accel_ctrl #(
    .IdWidth       (1),
    .DefaultTimeout(32'h0000_FFFF)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .aid_i         (aid_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .rid_o         (rid_o),
    .err_o         (err_o),
    .accel_start_o (accel_start_o),
    .accel_arg0_o  (accel_arg0_o),
    .accel_arg1_o  (accel_arg1_o),
    .accel_done_i  (accel_done_i),
    .accel_result_i(accel_result_i),
    .irq_o         (irq_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (accel_start_o) start_cnt++;
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One OBI transaction: drive, check grant, advance one edge, check the response.
  task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic id,
                     output logic [31:0] rd, output logic er);
    req_i   = 1'b1;
    we_i    = w;
    be_i    = b;
    addr_i  = a;
    wdata_i = d;
    aid_i   = id;
    #1;
    chk("gnt", {31'd0, gnt_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    we_i  = 1'b0;
    chk("rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("rid", {31'd0, rid_o}, {31'd0, id});
    rd = rdata_o;
    er = err_o;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic exp_err);
    logic [31:0] rd;
    logic        er;
    bus(1'b1, 4'hF, a, d, 1'b0, rd, er);
    chk({name, ".err"}, {31'd0, er}, {31'd0, exp_err});
    chk({name, ".rdata"}, rd, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    bus(1'b0, 4'hF, a, 32'd0, 1'b1, rd, er);
    chk({name, ".err"}, {31'd0, er}, 32'd0);
    chk({name, ".rdata"}, rd, exp);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".rvalid"}, {31'd0, rvalid_o}, 32'd0);
    chk({name, ".err"}, {31'd0, err_o}, 32'd0);
    chk({name, ".start"}, {31'd0, accel_start_o}, 32'd0);
    chk({name, ".irq"}, {31'd0, irq_o}, 32'd0);
    chk({name, ".rdata"}, rdata_o, 32'd0);
    chk({name, ".rid"}, {31'd0, rid_o}, 32'd0);
    chk({name, ".arg0"}, accel_arg0_o, 32'd0);
    chk({name, ".arg1"}, accel_arg1_o, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    // Reset state, and grant follows request even in reset.
    #12;
    chk_reset_outputs("rst");
    req_i = 1'b1;
    #1;
    chk("rst.gnt_hi", {31'd0, gnt_o}, 32'd1);
    req_i = 1'b0;
    #1;
    chk("rst.gnt_lo", {31'd0, gnt_o}, 32'd0);
    #10;
    rst_ni = 1'b1;
    tick();
    chk_reset_outputs("post_rst");

    // Register access table (all in IDLE).
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0008, 32'h0000_1234, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0008, 32'h0, 32'h0000_1234, 1'b0});
    vecs.push_back('{1'b1, 4'h3, 32'h0000_000C, 32'hAABB_5678, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_000C, 32'h0, 32'h0000_5678, 1'b0});
    vecs.push_back('{1'b1, 4'hC, 32'h0000_000C, 32'hAABB_FFFF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_000C, 32'h0, 32'hAABB_5678, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'h1, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0018, 32'h1, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0001, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 4'hE, 32'h0000_0000, 32'h0000_0002, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 4'h1, 32'h0000_0000, 32'h0000_0002, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0000_0002, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0014, 32'h0, 32'h0000_FFFF, 1'b0});
    vecs.push_back('{1'b1, 4'h1, 32'h0000_0014, 32'h1234_5620, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0014, 32'h0, 32'h0000_FF20, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_000C, 32'h0000_5678, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h2000_0008, 32'h0, 32'h0000_1234, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_001C, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 4'h1, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, i[0], rd, er);
      chk($sformatf("vec%0d.rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d.err", i), {31'd0, er}, {31'd0, vecs[i].err});
    end
    chk("arg0_o", accel_arg0_o, 32'h0000_1234);
    chk("arg1_o", accel_arg1_o, 32'h0000_5678);
    chk("no_start_yet", start_cnt, 0);

    // Normal completion in the fifth run cycle.
    wr("a.start", 32'h0, 32'h1, 1'b0);
    exp_starts++;
    chk("a.start_pulse", {31'd0, accel_start_o}, 32'd1);
    tick();
    chk("a.start_once", {31'd0, accel_start_o}, 32'd0);
    tick();
    tick();
    tick();
    accel_done_i   = 1'b1;
    accel_result_i = 32'h0000_CAFE;
    tick();
    accel_done_i   = 1'b0;
    accel_result_i = 32'h0;
    rd_chk("a.status", 32'h4, 32'h2);
    rd_chk("a.result", 32'h10, 32'h0000_CAFE);
    rd_chk("a.cycles", 32'h18, 32'd5);
    chk("a.starts", start_cnt, exp_starts);
    chk("a.irq_off", {31'd0, irq_o}, 32'd0);

    // Timeout after 8 cycles with interrupts enabled.
    wr("b.tmo", 32'h14, 32'd8, 1'b0);
    wr("b.start", 32'h0, 32'h3, 1'b0);
    exp_starts++;
    repeat (6) tick();
    rd_chk("b.status_run7", 32'h4, 32'h1);
    rd_chk("b.status_run8", 32'h4, 32'h1);
    rd_chk("b.status_tmo", 32'h4, 32'h4);
    rd_chk("b.cycles", 32'h18, 32'd8);
    rd_chk("b.result", 32'h10, 32'h0000_CAFE);
    chk("b.irq", {31'd0, irq_o}, 32'd1);
    wr("b.clear", 32'h0, 32'h6, 1'b0);
    rd_chk("b.status_clr", 32'h4, 32'h0);
    tick();
    chk("b.irq_clr", {31'd0, irq_o}, 32'd0);

    // Done coincides with timeout expiry; IRQ_EN off.
    wr("c.tmo", 32'h14, 32'd4, 1'b0);
    wr("c.start", 32'h0, 32'h1, 1'b0);
    exp_starts++;
    repeat (3) tick();
    accel_done_i   = 1'b1;
    accel_result_i = 32'h0000_BEEF;
    tick();
    accel_done_i   = 1'b0;
    rd_chk("c.status", 32'h4, 32'h2);
    rd_chk("c.result", 32'h10, 32'h0000_BEEF);
    tick();
    chk("c.irq_masked", {31'd0, irq_o}, 32'd0);

    // Busy-time protection, timeout disabled, START+CLEAR precedence.
    wr("d.tmo0", 32'h14, 32'd0, 1'b0);
    wr("d.startclr", 32'h0, 32'h5, 1'b0);
    exp_starts++;
    rd_chk("d.status_busy", 32'h4, 32'h1);
    wr("d.arg0_busy", 32'h8, 32'hDEAD_0000, 1'b1);
    wr("d.restart", 32'h0, 32'h1, 1'b0);
    wr("d.tmo_busy", 32'h14, 32'd3, 1'b1);
    bus(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, rd, er);
    chk("d.unmapped.err", {31'd0, er}, 32'd1);
    chk("d.unmapped.rdata", rd, 32'd0);
    rd_chk("d.arg0", 32'h8, 32'h0000_1234);
    repeat (20) tick();
    rd_chk("d.no_timeout", 32'h4, 32'h1);
    chk("d.starts", start_cnt, exp_starts);
    accel_done_i   = 1'b1;
    accel_result_i = 32'h0000_2222;
    tick();
    accel_done_i   = 1'b0;
    tick();
    accel_done_i   = 1'b1;
    accel_result_i = 32'h0000_1111;
    tick();
    accel_done_i   = 1'b0;
    rd_chk("d.result_idle_done", 32'h10, 32'h0000_2222);
    rd_chk("d.status", 32'h4, 32'h2);

    // Back-to-back reads with alternating IDs.
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h8;
    aid_i  = 1'b0;
    tick();
    chk("e.rvalid0", {31'd0, rvalid_o}, 32'd1);
    chk("e.rid0", {31'd0, rid_o}, 32'd0);
    aid_i  = 1'b1;
    addr_i = 32'hC;
    tick();
    req_i = 1'b0;
    chk("e.rvalid1", {31'd0, rvalid_o}, 32'd1);
    chk("e.rid1", {31'd0, rid_o}, 32'd1);
    chk("e.rdata1", rdata_o, 32'h0000_5678);
    tick();
    chk("e.rvalid_end", {31'd0, rvalid_o}, 32'd0);

    // Reset in the middle of a run.
    wr("f.start", 32'h0, 32'h3, 1'b0);
    exp_starts++;
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("f.rst");
    #10;
    rst_ni = 1'b1;
    repeat (4) tick();
    chk("f.no_start", start_cnt, exp_starts);
    rd_chk("f.timeout", 32'h14, 32'h0000_FFFF);
    rd_chk("f.status", 32'h4, 32'h0);
    rd_chk("f.ctrl", 32'h0, 32'h0);
    rd_chk("f.arg0", 32'h8, 32'h0);
    rd_chk("f.result", 32'h10, 32'h0);
    rd_chk("f.cycles", 32'h18, 32'h0);
    chk("f.irq", {31'd0, irq_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
